spio_spinnaker_link_transmitter: RTL and testbench

- Transmit end of the SpiNNaker link.
- Accepts one 72-bit spiNNlink packet per handshake and serialises it into 4-bit flits, least-significant nibble first.
- Encodes each flit as a 2-of-7 NRZ symbol on SL_DATA_2OF7_OUT and paces symbols by SL_ACK_IN transitions.
- Feeds a SpiNNaker chip, or the spio_spinnaker_link_receiver of another board.

---
 rtl/spio_spinnaker_link_transmitter.sv | 139 +++++++++++++
 tb/tb_spio_spinnaker_link_transmitter.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spio_spinnaker_link_transmitter.sv
// Purpose: transmit end of the SpiNNaker link; 72-bit packet -> 4-bit flits -> 2-of-7 NRZ symbols + EOP.
// Latency: packet accepted at edge N, first data-wire toggle after edge N+1; one symbol per ack transition.
// Backpressure: PKT_RDY_OUT is low from acceptance until the EOP symbol is acknowledged; a missing ack stalls forever.
module spio_spinnaker_link_transmitter (
   input  logic        CLK_IN,
   input  logic        RESET_IN,
   input  logic [71:0] PKT_DATA_IN,
   input  logic        PKT_VLD_IN,
   output logic        PKT_RDY_OUT,
   output logic [6:0]  SL_DATA_2OF7_OUT,
   input  logic        SL_ACK_IN
);

   localparam logic [2:0] STRT = 3'd0;
   localparam logic [2:0] IDLE = 3'd1;
   localparam logic [2:0] SEND = 3'd2;
   localparam logic [2:0] WACK = 3'd3;

   localparam logic [6:0] EOP_CODE    = 7'h60;
   localparam logic [4:0] SHORT_FLITS = 5'd10;
   localparam logic [4:0] LONG_FLITS  = 5'd18;

   logic        r_ack_s1;
   logic        r_ack_s2;
   logic        r_ack_prev;
   logic        w_ack_evt;

   logic [2:0]  r_state;
   logic [1:0]  r_strt_cnt;
   logic [71:0] r_buf;
   logic [4:0]  r_flits_left;
   logic        r_last;
   logic        r_pkt_rdy;
   logic [6:0]  r_sl_data;
   logic [6:0]  w_code;

   assign PKT_RDY_OUT      = r_pkt_rdy;
   assign SL_DATA_2OF7_OUT = r_sl_data;

   // Any change of the synchronised ack phase is one returned token.
   assign w_ack_evt = r_ack_s2 ^ r_ack_prev;

   // Two-flop synchroniser on the asynchronous ack plus last-seen phase.
   always_ff @(posedge CLK_IN or posedge RESET_IN) begin
      if (RESET_IN) begin
         r_ack_s1   <= 1'b0;
         r_ack_s2   <= 1'b0;
         r_ack_prev <= 1'b0;
      end else begin
         r_ack_s1   <= SL_ACK_IN;
         r_ack_s2   <= r_ack_s1;
         r_ack_prev <= r_ack_s2;
      end
   end

   // 2-of-7 code for the next flit (low nibble of the shift buffer).
   always_comb begin
      w_code = 7'h00;
      case (r_buf[3:0])
         4'h0: w_code = 7'h11;
         4'h1: w_code = 7'h12;
         4'h2: w_code = 7'h14;
         4'h3: w_code = 7'h18;
         4'h4: w_code = 7'h21;
         4'h5: w_code = 7'h22;
         4'h6: w_code = 7'h24;
         4'h7: w_code = 7'h28;
         4'h8: w_code = 7'h41;
         4'h9: w_code = 7'h42;
         4'hA: w_code = 7'h44;
         4'hB: w_code = 7'h48;
         4'hC: w_code = 7'h03;
         4'hD: w_code = 7'h06;
         4'hE: w_code = 7'h0C;
         4'hF: w_code = 7'h09;
      endcase
   end

   // Packet FSM: settle, accept, emit one symbol, wait for its ack.
   always_ff @(posedge CLK_IN or posedge RESET_IN) begin
      if (RESET_IN) begin
         r_state      <= STRT;
         r_strt_cnt   <= 2'd0;
         r_buf        <= 72'd0;
         r_flits_left <= 5'd0;
         r_last       <= 1'b0;
         r_pkt_rdy    <= 1'b0;
         r_sl_data    <= 7'h00;
      end else begin
         case (r_state)
            STRT: begin
               // Acks seen here only move ack_prev; the link starts with one token.
               if (r_strt_cnt == 2'd3) begin
                  r_state   <= IDLE;
                  r_pkt_rdy <= 1'b1;
               end else begin
                  r_strt_cnt <= r_strt_cnt + 2'd1;
               end
            end
            IDLE: begin
               r_pkt_rdy <= 1'b1;
               if (PKT_VLD_IN && r_pkt_rdy) begin
                  r_buf        <= PKT_DATA_IN;
                  r_flits_left <= PKT_DATA_IN[1] ? LONG_FLITS : SHORT_FLITS;
                  r_last       <= 1'b0;
                  r_pkt_rdy    <= 1'b0;
                  r_state      <= SEND;
               end
            end
            SEND: begin
               if (r_flits_left != 5'd0) begin
                  r_sl_data    <= r_sl_data ^ w_code;
                  r_buf        <= {4'h0, r_buf[71:4]};
                  r_flits_left <= r_flits_left - 5'd1;
               end else begin
                  r_sl_data <= r_sl_data ^ EOP_CODE;
                  r_last    <= 1'b1;
               end
               r_state <= WACK;
            end
            WACK: begin
               if (w_ack_evt) begin
                  if (r_last) begin
                     r_state   <= IDLE;
                     r_pkt_rdy <= 1'b1;
                  end else begin
                     r_state <= SEND;
                  end
               end
            end
            default: begin
               r_state   <= IDLE;
               r_pkt_rdy <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_spio_spinnaker_link_transmitter.sv
// Bench for the SpiNNaker link transmitter: directed packets, ack/receiver model on the wires.
// Latency: the ack model toggles the ack five cycles after each observed symbol.
// Backpressure: ack can be frozen to hold the transmitter in its wait state.
module tb_spio_spinnaker_link_transmitter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [71:0] pkt_data = 72'd0;
   logic        pkt_vld = 1'b0;
   logic        pkt_rdy;
   logic [6:0]  sl_data;
   logic        sl_ack = 1'b0;

   int n_chk = 0;
   int n_err = 0;

   // ack / receiver model state
   logic        ack_en = 1'b1;
   int          pend = 0;
   int          ack_cnt = 0;
   logic [6:0]  prev = 7'h00;
   logic [71:0] acc = 72'd0;
   int          acc_n = 0;
   logic [6:0]  st_q[$];
   logic [3:0]  nib_q[$];
   logic [71:0] rx_q[$];
   int          rxn_q[$];
   int          rx_cnt = 0;
   int          rx_rd = 0;

   spio_spinnaker_link_transmitter dut (
      .CLK_IN           (clk),
      .RESET_IN         (rst),
      .PKT_DATA_IN      (pkt_data),
      .PKT_VLD_IN       (pkt_vld),
      .PKT_RDY_OUT      (pkt_rdy),
      .SL_DATA_2OF7_OUT (sl_data),
      .SL_ACK_IN        (sl_ack)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic int dec(input logic [6:0] c);
      case (c)
         7'h11: return 0;   7'h12: return 1;   7'h14: return 2;   7'h18: return 3;
         7'h21: return 4;   7'h22: return 5;   7'h24: return 6;   7'h28: return 7;
         7'h41: return 8;   7'h42: return 9;   7'h44: return 10;  7'h48: return 11;
         7'h03: return 12;  7'h06: return 13;  7'h0C: return 14;  7'h09: return 15;
         7'h60: return 16;
         default: return 17;
      endcase
   endfunction

   // Far-end model: decode wire transitions, rebuild packets, return one ack per symbol.
   always @(negedge clk) begin
      logic [6:0]  delta;
      logic [71:0] nib;
      int          d;
      if (rst) begin
         prev  = 7'h00;
         pend  = 0;
         acc   = 72'd0;
         acc_n = 0;
      end else begin
         if (ack_en && pend > 0) begin
            pend--;
            if (pend == 0) begin
               sl_ack = ~sl_ack;
               ack_cnt++;
            end
         end
         if (sl_data !== prev) begin
            delta = sl_data ^ prev;
            prev  = sl_data;
            chk("one_outstanding", pend, 0);
            chk("two_wires", $countones(delta), 2);
            st_q.push_back(sl_data);
            d = dec(delta);
            if (d == 16) begin
               rx_q.push_back(acc);
               rxn_q.push_back(acc_n);
               rx_cnt++;
               acc   = 72'd0;
               acc_n = 0;
            end else if (d < 16) begin
               nib = 72'(d);
               acc = acc | (nib << (4 * acc_n));
               nib_q.push_back(4'(d));
               acc_n++;
            end else begin
               chk("sym_code", delta, 7'h00);
            end
            pend = 5;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_rdy(input string tag);
      int k = 0;
      while (pkt_rdy !== 1'b1 && k < 5000) begin
         tick();
         k++;
      end
      chk(tag, pkt_rdy, 1'b1);
   endtask

   task automatic wait_rx(input string tag, input int n);
      int k = 0;
      while (rx_cnt < n && k < 5000) begin
         tick();
         k++;
      end
      chk(tag, rx_cnt, n);
   endtask

   task automatic wait_ack(input string tag, input int n);
      int k = 0;
      while (ack_cnt < n && k < 5000) begin
         tick();
         k++;
      end
      chk(tag, ack_cnt, n);
   endtask

   task automatic wait_nib(input string tag, input int n);
      int k = 0;
      while (nib_q.size() < n && k < 5000) begin
         tick();
         k++;
      end
      chk(tag, (nib_q.size() >= n), 1'b1);
   endtask

   task automatic check_rx(input string tag, input logic [71:0] exp, input int exp_n);
      if (rx_rd < rx_q.size()) begin
         chk({tag, "_data"}, rx_q[rx_rd], exp);
         chk({tag, "_flits"}, rxn_q[rx_rd], exp_n);
         rx_rd++;
      end else begin
         chk({tag, "_present"}, rx_q.size(), rx_rd + 1);
      end
   endtask

   task automatic send(input logic [71:0] d);
      wait_rdy("send_rdy");
      pkt_data = d;
      pkt_vld  = 1'b1;
      tick();
      pkt_vld  = 1'b0;
   endtask

   initial begin
      logic [71:0] s_pkt, l1, l2, pa, pb, pp, pc;
      logic [3:0]  tail [8];
      logic [6:0]  w0;
      int          a0, r0, changes, rdy_hi;

      s_pkt = {32'hCAFEBABE, 40'h12345678_00};
      l1    = {32'hDEADBEEF, 32'h87654321, 8'h02};
      l2    = {32'h0F1E2D3C, 32'hA5A55A5A, 8'hC2};
      pa    = {32'h99999999, 32'h11223344, 8'h40};
      pb    = {32'hFFFF0000, 32'h00000000, 8'hFE};
      pp    = {32'h0, 40'hAAAAAAAA_01};
      pc    = {32'h13579BDF, 32'h2468ACE0, 8'h03};
      tail  = '{4'hF, 4'hE, 4'hE, 4'hB, 4'hD, 4'hA, 4'hE, 4'hD};

      // reset state and ready timing
      #20;
      chk("rst_rdy", pkt_rdy, 1'b0);
      chk("rst_wires", sl_data, 7'h00);
      #2 rst = 1'b0;
      for (int e = 1; e <= 4; e++) begin
         tick();
         chk($sformatf("strt_rdy_edge%0d", e), pkt_rdy, (e == 4));
         chk("strt_wires", sl_data, 7'h00);
      end

      // short packet: latency, wire sequence, ack count, ready return
      st_q.delete(); nib_q.delete();
      a0 = ack_cnt; r0 = rx_cnt;
      wait_rdy("short_rdy");
      pkt_data = s_pkt;
      pkt_vld  = 1'b1;
      tick();
      pkt_vld  = 1'b0;
      chk("short_accept_rdy", pkt_rdy, 1'b0);
      chk("short_lat_edge_n", sl_data, 7'h00);
      tick();
      chk("short_lat_edge_n1", sl_data, 7'h11);
      wait_ack("short_acks", a0 + 11);
      chk("short_rdy_sync1", pkt_rdy, 1'b0);
      tick();
      chk("short_rdy_sync2", pkt_rdy, 1'b0);
      tick();
      chk("short_rdy_back", pkt_rdy, 1'b1);
      wait_rx("short_rx", r0 + 1);
      check_rx("short", {32'h0, s_pkt[39:0]}, 10);
      chk("short_st0", st_q[0], 7'h11);
      chk("short_st1", st_q[1], 7'h00);
      chk("short_st2", st_q[2], 7'h41);
      chk("short_st3", st_q[3], 7'h69);
      chk("short_eop", st_q[10] ^ st_q[9], 7'h60);
      repeat (20) tick();
      chk("short_nsym", st_q.size(), 11);
      chk("short_no_extra_ack", ack_cnt, a0 + 11);

      // long packet with DEADBEEF payload
      st_q.delete(); nib_q.delete();
      r0 = rx_cnt;
      send(l1);
      wait_rx("long_rx", r0 + 1);
      check_rx("long", l1, 18);
      chk("long_nsym", st_q.size(), 19);
      for (int i = 0; i < 8; i++)
         chk($sformatf("long_tail%0d", i), nib_q[10 + i], tail[i]);

      // ack withheld mid-packet
      st_q.delete(); nib_q.delete();
      r0 = rx_cnt;
      send(l2);
      wait_nib("stall_start", 4);
      ack_en  = 1'b0;
      w0      = sl_data;
      changes = 0;
      rdy_hi  = 0;
      repeat (1000) begin
         tick();
         if (sl_data !== w0) changes++;
         if (pkt_rdy === 1'b1) rdy_hi++;
      end
      chk("stall_wires_stable", changes, 0);
      chk("stall_rdy_low", rdy_hi, 0);
      ack_en = 1'b1;
      wait_rx("stall_rx", r0 + 1);
      check_rx("stall", l2, 18);
      chk("stall_nsym", st_q.size(), 19);

      // back-to-back with valid held high
      r0 = rx_cnt; a0 = ack_cnt;
      pkt_data = pa;
      pkt_vld  = 1'b1;
      wait_rdy("b2b_rdy_a");
      tick();
      chk("b2b_accept_a", pkt_rdy, 1'b0);
      pkt_data = pb;
      wait_rdy("b2b_rdy_b");
      tick();
      chk("b2b_accept_b", pkt_rdy, 1'b0);
      pkt_vld = 1'b0;
      wait_rx("b2b_rx", r0 + 2);
      check_rx("b2b_a", {32'h0, pa[39:0]}, 10);
      check_rx("b2b_b", pb, 18);
      wait_ack("b2b_acks", a0 + 30);

      // reset mid-packet, then a clean packet
      nib_q.delete();
      send(pp);
      wait_nib("rst_mid_start", 4);
      rst = 1'b1;
      #1;
      chk("rst_mid_wires", sl_data, 7'h00);
      chk("rst_mid_rdy", pkt_rdy, 1'b0);
      tick();
      tick();
      rst = 1'b0;
      r0 = rx_cnt;
      send(pc);
      wait_rx("rst_new_rx", r0 + 1);
      check_rx("rst_new", pc, 18);
      repeat (20) tick();
      chk("rst_one_pkt", rx_cnt, r0 + 1);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
